// File: rtl/full_adder_cell.sv
// One-bit full adder; the leaf of the ripple chain.
// Sum and carry-out from a, b and carry in.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term is shared by the sum and the carry path.
    always_comb begin
        p    = a ^ b;
        s    = p ^ cin;
        cout = (a & b) | (cin & p);
    end

endmodule

// File: rtl/full_adder_unit.sv
// Ripple-carry adder: {carry_out, sum} = a + b + carry_in.
// Optional output register with a valid flag.
module full_adder_unit #(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    if (REGISTERED) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             co_q;
        logic             vld_q;

        // Capture the result on valid operands; hold it otherwise.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q <= '0;
                co_q  <= 1'b0;
            end else if (in_valid) begin
                sum_q <= s;
                co_q  <= c[WIDTH];
            end
        end

        // Valid flag tracks in_valid with one cycle of latency.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else begin
                vld_q <= in_valid;
            end
        end

        assign sum       = sum_q;
        assign carry_out = co_q;
        assign out_valid = vld_q;
    end else begin : g_comb
        assign sum       = s;
        assign carry_out = c[WIDTH];
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed bench: exhaustive 1-bit combinational adder,
// then the 8-bit registered adder (latency, hold, reset).
module tb_full_adder_unit;

    logic clk;
    logic rst;

    logic       c_vld;
    logic [0:0] c_a;
    logic [0:0] c_b;
    logic       c_ci;
    logic [0:0] c_s;
    logic       c_co;
    logic       c_ov;

    logic       r_vld;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_ci;
    logic [7:0] r_s;
    logic       r_co;
    logic       r_ov;

    int checks;
    int errors;

    full_adder_unit #(.WIDTH(1), .REGISTERED(1'b0)) u_c1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (c_vld),
        .a         (c_a),
        .b         (c_b),
        .carry_in  (c_ci),
        .sum       (c_s),
        .carry_out (c_co),
        .out_valid (c_ov)
    );

    full_adder_unit #(.WIDTH(8), .REGISTERED(1'b1)) u_r8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_vld),
        .a         (r_a),
        .b         (r_b),
        .carry_in  (r_ci),
        .sum       (r_s),
        .carry_out (r_co),
        .out_valid (r_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one operand set at negedge; check after the next posedge.
    task automatic step(
        input string      tag,
        input logic       v,
        input logic [7:0] a,
        input logic [7:0] b,
        input logic       ci,
        input logic [8:0] exp,
        input logic       ev
    );
        @(negedge clk);
        r_vld = v;
        r_a   = a;
        r_b   = b;
        r_ci  = ci;
        @(posedge clk);
        #1;
        check({tag, " res"}, {23'd0, r_co, r_s}, {23'd0, exp});
        check({tag, " vld"}, {31'd0, r_ov}, {31'd0, ev});
    endtask

    logic [1:0] tt_exp [8];

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        c_vld  = 1'b0;
        c_a    = '0;
        c_b    = '0;
        c_ci   = 1'b0;
        r_vld  = 1'b0;
        r_a    = '0;
        r_b    = '0;
        r_ci   = 1'b0;

        // Index {a,b,cin}: expected {co,s}.
        tt_exp[0] = 2'b00;
        tt_exp[1] = 2'b01;
        tt_exp[2] = 2'b01;
        tt_exp[3] = 2'b10;
        tt_exp[4] = 2'b01;
        tt_exp[5] = 2'b10;
        tt_exp[6] = 2'b10;
        tt_exp[7] = 2'b11;

        for (int i = 0; i < 8; i++) begin
            c_a   = 1'(i >> 2);
            c_b   = 1'(i >> 1);
            c_ci  = 1'(i);
            c_vld = 1'(i);
            #10;
            check($sformatf("tt%0d", i), {30'd0, c_co, c_s},
                  {30'd0, tt_exp[i]});
            check($sformatf("tt%0d vld", i), {31'd0, c_ov},
                  {31'd0, 1'(i)});
        end

        @(negedge clk);
        check("rst res", {23'd0, r_co, r_s}, 32'd0);
        check("rst vld", {31'd0, r_ov}, 32'd0);
        rst = 1'b0;

        step("ff+00+1", 1'b1, 8'hFF, 8'h00, 1'b1, 9'h100, 1'b1);
        step("5a+25+0", 1'b1, 8'h5A, 8'h25, 1'b0, 9'h07F, 1'b1);
        step("hold",    1'b0, 8'h12, 8'h34, 1'b1, 9'h07F, 1'b0);
        step("hold2",   1'b0, 8'hFF, 8'hFF, 1'b1, 9'h07F, 1'b0);
        step("ff+ff+1", 1'b1, 8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1);
        step("80+80+0", 1'b1, 8'h80, 8'h80, 1'b0, 9'h100, 1'b1);
        step("0f+01+0", 1'b1, 8'h0F, 8'h01, 1'b0, 9'h010, 1'b1);
        step("aa+55+1", 1'b1, 8'hAA, 8'h55, 1'b1, 9'h100, 1'b1);
        step("5a+25+1", 1'b1, 8'h5A, 8'h25, 1'b1, 9'h080, 1'b1);

        // Async reset between edges clears at once.
        #2;
        rst = 1'b1;
        #1;
        check("arst res", {23'd0, r_co, r_s}, 32'd0);
        check("arst vld", {31'd0, r_ov}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        r_vld = 1'b0;
        step("post rst", 1'b0, 8'h11, 8'h22, 1'b0, 9'h000, 1'b0);

        step("b2b0", 1'b1, 8'h01, 8'h01, 1'b0, 9'h002, 1'b1);
        step("b2b1", 1'b1, 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
        step("b2b2", 1'b1, 8'h33, 8'h44, 1'b1, 9'h078, 1'b1);
        step("b2b3", 1'b1, 8'hC8, 8'h64, 1'b0, 9'h12C, 1'b1);
        step("drain", 1'b0, 8'h00, 8'h00, 1'b0, 9'h12C, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
